axi_dac_jesd204_sync_seq: RTL and testbench
===========================================

# axi_dac_jesd204_sync_seq

Sync sequencer for the JESD204 DAC channel datapaths. Arbitrates resynchronisation requests from several sources and mutes the channel outputs around the event. Aligns a single-cycle `dac_data_sync` pulse to the link's LMFC boundary. This resets the DDS phase accumulators and PN generators of every channel coherently. Sits in the `dac_clk` domain between the common register block / trigger logic and all channel instances.

## Interface
Parameters:
- NUM_REQ, 3, number of sync requesters; index 0 has highest priority.
- PRE_CYCLES, 4, cycles of mute before waiting for the sync edge; range 1..255.
- SETTLE_CYCLES, 8, cycles of mute after the sync pulse; range 1..255.
- TIMEOUT_CYCLES, 1024, maximum cycles spent waiting for the edge; range 2..65535.

Ports:
- dac_clk  in  1  datapath clock; the only clock in the block.
- dac_rstn  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request pulses, sampled every cycle.
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse marking a successfully serviced request.
- grant  out  NUM_REQ  one-hot requester currently being serviced; zero when idle.
- link_ready  in  1  JESD link in DATA phase.
- lmfc_edge  in  1  one-cycle pulse at each LMFC boundary.
- dac_data_sync  out  1  sync pulse to the channels.
- dac_mute  out  1  forces channel data to zero while high.
- busy  out  1  high whenever the state is not IDLE.
- timeout_err  out  1  sticky timeout flag.
- err_clr  in  1  clears `timeout_err`.

## Operation
- Pending register, NUM_REQ bits:
  - A bit is set when its `req` bit is high.
  - A bit is cleared on the cycle that requester is acked or aborted.
  - Set wins over clear on the same cycle.
  - Repeated requests from one source collapse into one pending bit.
- States: IDLE, PRE, WAIT, SYNC, SETTLE.
- IDLE:
  - When pending is nonzero, grant the lowest set index and go to PRE.
  - Load the counter with PRE_CYCLES-1.
- PRE: count down; at 0, go to WAIT with the counter cleared.
- WAIT:
  - Exit to SYNC when `link_ready` is high and (`lmfc_edge` is high, or alignment is disabled).
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CYCLES-1 with no exit condition, go to IDLE:
    - set `timeout_err`;
    - clear the granted pending bit;
    - give no `req_ack`.
  - If the exit condition and the timeout hit on the same cycle, the exit wins.
- SYNC: lasts one cycle; go to SETTLE with the counter loaded to SETTLE_CYCLES-1.
- SETTLE:
  - Count down; at 0, go to IDLE.
  - Pulse `req_ack[grant]` and clear the pending bit.
  - Loss of `link_ready` during SETTLE is ignored.
- `grant` is held constant from the IDLE→PRE transition until the return to IDLE.
- Requests arriving while busy are only latched. The next arbitration happens in IDLE, at least one cycle after returning.
- `timeout_err`:
  - Set by a timeout.
  - Cleared by `err_clr`.
  - Set wins if both occur on the same cycle.
- Counter: 16 bits; comparisons are unsigned; no wrap is reachable within the parameter ranges.

## Timing
- All outputs are registered and decoded from the next state.
- Reset values: `req_ack`=0, `grant`=0, `dac_data_sync`=0, `dac_mute`=0, `busy`=0, `timeout_err`=0; state is IDLE and pending is 0.
- Reset asserted mid-sequence aborts immediately, with no ack and no sync.
- Request latency, with `req` pulsed at cycle 0:
  - pending is set at cycle 1;
  - `grant`, `busy` and `dac_mute` go high at cycle 2;
  - PRE occupies cycles 2..PRE_CYCLES+1.
- Sync timing: when the edge condition is met at WAIT cycle t, `dac_data_sync`=1 at cycle t+1 only.
- `dac_mute`:
  - High continuously from PRE entry through the last SETTLE cycle.
  - Low at the same cycle the `req_ack` pulse is high and `busy`/`grant` drop.
- Minimum request-to-ack time with alignment disabled and `link_ready`=1 is 2+PRE_CYCLES+1+1+SETTLE_CYCLES cycles.

## Configuration
- `AXI_DAC_JESD204_SYNC_LMFC_ALIGN_EN` defined:
  - WAIT requires `lmfc_edge` together with `link_ready`;
  - the timeout is active.
- Not defined:
  - `lmfc_edge` is ignored;
  - WAIT exits on the first cycle `link_ready` is high;
  - the timeout still applies while `link_ready` stays low.

## Test plan
- Single request, alignment on:
  - Stimulus: PRE=4, SETTLE=8; `req[1]` pulsed at cycle 0; `link_ready`=1; `lmfc_edge` at cycle 10.
  - Response: mute high over cycles 2..19; sync at cycle 11 only; `req_ack`=3'b010 at cycle 20.
- Priority:
  - Stimulus: `req`=3'b110 at cycle 0, then `req[0]` pulsed during the first sequence.
  - Response: grant order 3'b010, 3'b001, 3'b100; each `req_ack` occurs once.
- Timeout:
  - Stimulus: TIMEOUT=16, `link_ready`=0.
  - Response: `timeout_err` set; no sync, no ack; mute drops; pending bit cleared; `err_clr` returns the flag to 0.
- Collapse and set-wins:
  - Stimulus: `req[2]` pulsed 3 times while busy, the last pulse on its own ack cycle.
  - Response: exactly one further sequence for requester 2.
- Reset mid-SETTLE:
  - Stimulus: assert `dac_rstn`=0.
  - Response: all outputs are 0 on the same cycle (asynchronous); no ack after release.
- Macro undefined:
  - Stimulus: `lmfc_edge` tied 0, `link_ready`=1.
  - Response: sync occurs PRE_CYCLES+3 cycles after `req`.

Source files
------------

// File: rtl/axi_dac_jesd204_sync_seq.sv
// Sync sequencer for the JESD204 DAC datapaths: arbitrates sync requests, mutes channels, emits LMFC-aligned sync.
// Optional macro AXI_DAC_JESD204_SYNC_LMFC_ALIGN_EN gates the sync edge on lmfc_edge.
module axi_dac_jesd204_sync_seq #(
  parameter int NUM_REQ        = 3,
  parameter int PRE_CYCLES     = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               dac_clk,
  input  logic               dac_rstn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] req_ack,
  output logic [NUM_REQ-1:0] grant,
  input  logic               link_ready,
  input  logic               lmfc_edge,
  output logic               dac_data_sync,
  output logic               dac_mute,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr
);

  typedef enum logic [2:0] {IDLE, PRE, WAIT, SYNC, SETTLE} state_t;

  localparam logic [15:0] PRE_LOAD    = 16'(PRE_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_t             state;
  logic [15:0]        cnt;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] clr_mask;
  logic [NUM_REQ-1:0] lowest_pending;
  logic               wait_exit;

`ifdef AXI_DAC_JESD204_SYNC_LMFC_ALIGN_EN
  assign wait_exit = link_ready & lmfc_edge;
`else
  logic unused_lmfc_edge;
  assign unused_lmfc_edge = lmfc_edge;
  assign wait_exit        = link_ready;
`endif

  // Isolate the lowest set bit: index 0 has the highest priority.
  assign lowest_pending = pending & (~pending + NUM_REQ'(1));

  // clr_mask holds the requester just acked or aborted for one cycle: it drops
  // that pending bit (a same-cycle req re-sets it) and blocks arbitration in
  // the first IDLE cycle after a sequence.
  always_ff @(posedge dac_clk or negedge dac_rstn) begin
    if (!dac_rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      pending       <= '0;
      clr_mask      <= '0;
      req_ack       <= '0;
      grant         <= '0;
      dac_data_sync <= 1'b0;
      dac_mute      <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      pending       <= (pending & ~clr_mask) | req;
      clr_mask      <= '0;
      req_ack       <= '0;
      dac_data_sync <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (clr_mask == '0 && pending != '0) begin
            state    <= PRE;
            grant    <= lowest_pending;
            busy     <= 1'b1;
            dac_mute <= 1'b1;
            cnt      <= PRE_LOAD;
          end
        end
        PRE: begin
          if (cnt == '0) begin
            state <= WAIT;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        WAIT: begin
          if (wait_exit) begin
            state         <= SYNC;
            dac_data_sync <= 1'b1;
          end else if (cnt == TMO_LAST) begin
            state       <= IDLE;
            clr_mask    <= grant;
            grant       <= '0;
            busy        <= 1'b0;
            dac_mute    <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SYNC: begin
          state <= SETTLE;
          cnt   <= SETTLE_LOAD;
        end
        SETTLE: begin
          if (cnt == '0) begin
            state    <= IDLE;
            req_ack  <= grant;
            clr_mask <= grant;
            grant    <= '0;
            busy     <= 1'b0;
            dac_mute <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          busy     <= 1'b0;
          dac_mute <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_dac_jesd204_sync_seq.sv
// Directed self-checking bench for axi_dac_jesd204_sync_seq (PRE=4, SETTLE=8, TIMEOUT=16).
// Expectations follow AXI_DAC_JESD204_SYNC_LMFC_ALIGN_EN when the bench is built with it.
module tb_axi_dac_jesd204_sync_seq;

  localparam int PRE     = 4;
  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 16;

`ifdef AXI_DAC_JESD204_SYNC_LMFC_ALIGN_EN
  localparam bit ALIGN    = 1'b1;
  localparam int SYNC_CYC = 11;
  localparam int ACK_CYC  = 20;
`else
  localparam bit ALIGN    = 1'b0;
  localparam int SYNC_CYC = 7;
  localparam int ACK_CYC  = 16;
`endif

  logic       dac_clk = 1'b0;
  logic       dac_rstn;
  logic [2:0] req;
  logic [2:0] req_ack;
  logic [2:0] grant;
  logic       link_ready;
  logic       lmfc_edge;
  logic       dac_data_sync;
  logic       dac_mute;
  logic       busy;
  logic       timeout_err;
  logic       err_clr;

  int checks = 0;
  int errors = 0;

  axi_dac_jesd204_sync_seq #(
    .NUM_REQ       (3),
    .PRE_CYCLES    (PRE),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .dac_clk      (dac_clk),
    .dac_rstn     (dac_rstn),
    .req          (req),
    .req_ack      (req_ack),
    .grant        (grant),
    .link_ready   (link_ready),
    .lmfc_edge    (lmfc_edge),
    .dac_data_sync(dac_data_sync),
    .dac_mute     (dac_mute),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .err_clr      (err_clr)
  );

  always #5 dac_clk = ~dac_clk;

  // Step to 1 ns after the next rising edge, where inputs are driven and outputs sampled.
  task automatic tick();
    @(posedge dac_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] r, input logic lr, input logic le, input logic ec);
    req        = r;
    link_ready = lr;
    lmfc_edge  = le;
    err_clr    = ec;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkCycle(input string tag, input int c, input logic [2:0] ex_grant,
                            input logic [2:0] ex_ack, input logic ex_sync, input logic ex_err);
    checkOutput($sformatf("%s_c%0d_grant", tag, c), 32'(grant), 32'(ex_grant));
    checkOutput($sformatf("%s_c%0d_ack", tag, c), 32'(req_ack), 32'(ex_ack));
    checkOutput($sformatf("%s_c%0d_sync", tag, c), 32'(dac_data_sync), 32'(ex_sync));
    checkOutput($sformatf("%s_c%0d_mute", tag, c), 32'(dac_mute), 32'(ex_grant != 3'b000));
    checkOutput($sformatf("%s_c%0d_busy", tag, c), 32'(busy), 32'(ex_grant != 3'b000));
    checkOutput($sformatf("%s_c%0d_err", tag, c), 32'(timeout_err), 32'(ex_err));
  endtask

  // Back-to-back sequences each last ACK_CYC cycles; sequence k is granted over
  // cycles k*ACK_CYC+2 .. (k+1)*ACK_CYC-1 and acked at (k+1)*ACK_CYC.
  task automatic expSeq(input int c, input int nseq, input logic [8:0] ord,
                        output logic [2:0] g, output logic [2:0] a, output logic s);
    int k;
    int r;
    k = c / ACK_CYC;
    r = c % ACK_CYC;
    g = 3'b000;
    a = 3'b000;
    s = 1'b0;
    if (k < nseq && r >= 2) g = ord[k*3 +: 3];
    if (k >= 1 && k <= nseq && r == 0) a = ord[(k-1)*3 +: 3];
    if (k < nseq && r == SYNC_CYC) s = 1'b1;
  endtask

  initial begin
    logic [2:0] eg;
    logic [2:0] ea;
    logic       es;
    logic [2:0] rv;

    dac_rstn = 1'b0;
    applyStimulus(3'b000, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    $display("[TB] reset state");
    checkCycle("reset", 0, 3'b000, 3'b000, 1'b0, 1'b0);
    dac_rstn = 1'b1;
    tick();

    $display("[TB] single request from requester 1");
    for (int c = 0; c <= ACK_CYC + 3; c++) begin
      applyStimulus((c == 0) ? 3'b010 : 3'b000, 1'b1, ALIGN && (c == 10), 1'b0);
      checkCycle("single", c,
                 (c >= 2 && c <= ACK_CYC - 1) ? 3'b010 : 3'b000,
                 (c == ACK_CYC) ? 3'b010 : 3'b000,
                 c == SYNC_CYC, 1'b0);
      tick();
    end

    $display("[TB] priority: 110 then 001 during first sequence");
    for (int c = 0; c <= 3 * ACK_CYC + 3; c++) begin
      rv = 3'b000;
      if (c == 0) rv = 3'b110;
      if (c == 5) rv = 3'b001;
      applyStimulus(rv, 1'b1, ALIGN && (c % ACK_CYC == 10), 1'b0);
      expSeq(c, 3, {3'b100, 3'b001, 3'b010}, eg, ea, es);
      checkCycle("prio", c, eg, ea, es, 1'b0);
      tick();
    end

    $display("[TB] collapse and set-wins for requester 2");
    for (int c = 0; c <= 2 * ACK_CYC + 3; c++) begin
      rv = (c == 0 || c == 5 || c == 8 || c == ACK_CYC) ? 3'b100 : 3'b000;
      applyStimulus(rv, 1'b1, ALIGN && (c % ACK_CYC == 10), 1'b0);
      expSeq(c, 2, {3'b000, 3'b100, 3'b100}, eg, ea, es);
      checkCycle("collapse", c, eg, ea, es, 1'b0);
      tick();
    end

    // WAIT spans cycles 6..21, so the abort lands at cycle 22.
    $display("[TB] timeout with link down");
    for (int c = 0; c <= 29; c++) begin
      applyStimulus((c == 0) ? 3'b001 : 3'b000, 1'b0, ALIGN && (c == 10), c == 27);
      checkCycle("timeout", c,
                 (c >= 2 && c <= 21) ? 3'b001 : 3'b000,
                 3'b000, 1'b0, (c >= 22 && c <= 27));
      tick();
    end

    $display("[TB] reset during SETTLE");
    for (int c = 0; c <= SYNC_CYC + 3; c++) begin
      applyStimulus((c == 0) ? 3'b010 : 3'b000, 1'b1, ALIGN && (c == 10), 1'b0);
      tick();
    end
    checkOutput("rst_pre_mute", 32'(dac_mute), 32'd1);
    checkOutput("rst_pre_grant", 32'(grant), 32'd2);
    #2;
    dac_rstn = 1'b0;
    #1;
    checkCycle("rst_async", 0, 3'b000, 3'b000, 1'b0, 1'b0);
    tick();
    tick();
    dac_rstn = 1'b1;
    for (int c = 0; c <= ACK_CYC + 4; c++) begin
      applyStimulus(3'b000, 1'b1, ALIGN && (c % ACK_CYC == 10), 1'b0);
      tick();
      checkCycle("rst_after", c, 3'b000, 3'b000, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
